// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Front-panel time-setting controller for the 24-hour clock. Debounces the
//   MODE and UP buttons, steps through the set modes and issues one-CLK
//   INC/CLR strobes to the hour, minute and second counters. UP auto-repeats
//   while held in SET_HOUR / SET_MIN.
//
// Ports
//   CLK       in   system clock
//   RST       in   asynchronous reset, active-low
//   EN        in   one-CLK sampling tick (prescaled base tick)
//   BTN_MODE  in   raw MODE button, asynchronous, active-high
//   BTN_UP    in   raw UP button, asynchronous, active-high
//   SET_MODE  out  0=NORMAL, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
//   HOLD      out  high whenever SET_MODE != 0
//   HOURINC   out  one-CLK strobe to hour counter INC
//   MININC    out  one-CLK strobe to minute counter INC
//   SECCLR    out  one-CLK strobe to second counter CLR
//
// Optional feature macro: TIME_SET_TIMEOUT_EN
//   When defined, set mode is abandoned after TMO_TICKS idle EN ticks.
//   When undefined, set mode persists until MODE cycles back to NORMAL.
//
// Parameter assumptions: DEB_CYC >= 2, REP_DLY >= 2, 1 <= REP_PER <= REP_DLY.

module time_set_ctrl #(
  parameter int DEB_CYC   = 4,
  parameter int REP_DLY   = 8,
  parameter int REP_PER   = 2,
  parameter int TMO_TICKS = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [1:0] SET_MODE,
  output logic       HOLD,
  output logic       HOURINC,
  output logic       MININC,
  output logic       SECCLR
);

  localparam int DCW = $clog2(DEB_CYC);
  localparam int RCW = $clog2(REP_DLY + 1);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  // Bit 0 = MODE button, bit 1 = UP button
  logic [1:0]     sync0, sync1;
  logic [1:0]     deb_lvl, deb_prev;
  logic [DCW-1:0] deb_cnt [2];
  logic           en_q;

  logic           mode_press, up_press, up_lvl;

  mode_t          state, state_nxt;
  logic           armed, armed_nxt;
  logic [RCW-1:0] rcnt, rcnt_nxt;
  logic           hour_q, min_q, sec_q;
  logic           hour_nxt, min_nxt, sec_nxt;

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TW = $clog2(TMO_TICKS + 1);
  logic [TW-1:0]  idle, idle_nxt;
`else
  logic           unused_tmo;
  assign unused_tmo = (TMO_TICKS > 0);
`endif

  // Synchronizers run every CLK; the debounce counters only advance on EN.
  // deb_prev lags deb_lvl by one CLK so a press is visible for exactly one
  // cycle, the cycle after the debounced flip.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync0      <= '0;
      sync1      <= '0;
      deb_lvl    <= '0;
      deb_prev   <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      en_q       <= 1'b0;
    end else begin
      sync0    <= {BTN_UP, BTN_MODE};
      sync1    <= sync0;
      deb_prev <= deb_lvl;
      en_q     <= EN;
      if (EN) begin
        for (int b = 0; b < 2; b++) begin
          if (sync1[b] == deb_lvl[b]) begin
            deb_cnt[b] <= '0;
          end else if (deb_cnt[b] == DCW'(DEB_CYC - 1)) begin
            deb_lvl[b] <= ~deb_lvl[b];
            deb_cnt[b] <= '0;
          end else begin
            deb_cnt[b] <= deb_cnt[b] + 1'b1;
          end
        end
      end
    end
  end

  assign mode_press = deb_lvl[0] & ~deb_prev[0];
  assign up_press   = deb_lvl[1] & ~deb_prev[1];
  assign up_lvl     = deb_lvl[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= NORMAL;
      armed  <= 1'b0;
      rcnt   <= '0;
      hour_q <= 1'b0;
      min_q  <= 1'b0;
      sec_q  <= 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
      idle   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      armed  <= armed_nxt;
      rcnt   <= rcnt_nxt;
      hour_q <= hour_nxt;
      min_q  <= min_nxt;
      sec_q  <= sec_nxt;
`ifdef TIME_SET_TIMEOUT_EN
      idle   <= idle_nxt;
`endif
    end
  end

  // The repeat counter works on en_q so that each repeat strobe lands one
  // cycle after the EN tick that completes the count, matching the first
  // strobe which lands one cycle after the debounce tick. The first strobe's
  // debounce tick is tick 0. After the first repeat the counter is rewound
  // by REP_PER so subsequent strobes come every REP_PER ticks.
  always_comb begin
    state_nxt = state;
    armed_nxt = armed;
    rcnt_nxt  = rcnt;
    hour_nxt  = 1'b0;
    min_nxt   = 1'b0;
    sec_nxt   = 1'b0;

    if (mode_press) begin
      // MODE wins over a simultaneous UP press and always disarms repeat.
      case (state)
        NORMAL:   state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        SET_MIN:  state_nxt = SET_SEC;
        default:  state_nxt = NORMAL;
      endcase
      armed_nxt = 1'b0;
      rcnt_nxt  = '0;
    end else if (up_press && (state != NORMAL)) begin
      hour_nxt  = (state == SET_HOUR);
      min_nxt   = (state == SET_MIN);
      sec_nxt   = (state == SET_SEC);
      armed_nxt = (state != SET_SEC);
      rcnt_nxt  = '0;
    end else if (!up_lvl) begin
      armed_nxt = 1'b0;
      rcnt_nxt  = '0;
    end else if (armed && en_q) begin
      if (rcnt == RCW'(REP_DLY - 1)) begin
        hour_nxt = (state == SET_HOUR);
        min_nxt  = (state == SET_MIN);
        rcnt_nxt = RCW'(REP_DLY - REP_PER);
      end else begin
        rcnt_nxt = rcnt + 1'b1;
      end
    end

`ifdef TIME_SET_TIMEOUT_EN
    // A press or a held UP keeps the idle count at zero, so a timeout can
    // never coincide with a strobe.
    idle_nxt = idle;
    if ((state == NORMAL) || mode_press || up_press || up_lvl) begin
      idle_nxt = '0;
    end else if (idle == TW'(TMO_TICKS)) begin
      idle_nxt  = '0;
      state_nxt = NORMAL;
      armed_nxt = 1'b0;
      rcnt_nxt  = '0;
    end else if (EN) begin
      idle_nxt = idle + 1'b1;
    end
`endif
  end

  assign SET_MODE = state;
  assign HOLD     = (state != NORMAL);
  assign HOURINC  = hour_q;
  assign MININC   = min_q;
  assign SECCLR   = sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl
//   Directed bench for time_set_ctrl with default parameters and EN high
//   every cycle. A vector table covers mode selection and UP hold lengths;
//   hand-written sequences cover press latency, repeat spacing, bounce,
//   simultaneous MODE/UP, and asynchronous reset during a repeat.

module tb_time_set_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       BTN_MODE;
  logic       BTN_UP;
  logic [1:0] SET_MODE;
  logic       HOLD;
  logic       HOURINC;
  logic       MININC;
  logic       SECCLR;

  int testsRun    = 0;
  int testsFailed = 0;

  int edgeNo;
  int hourCnt, minCnt, secCnt, multiCnt;
  int hourEdges[$];
  int minEdges[$];

  typedef struct {
    int modes;
    int hold;
    int expMode;
    int expHour;
    int expMin;
    int expSec;
  } vec_t;

  vec_t vecs[8];

  time_set_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .BTN_MODE (BTN_MODE),
    .BTN_UP   (BTN_UP),
    .SET_MODE (SET_MODE),
    .HOLD     (HOLD),
    .HOURINC  (HOURINC),
    .MININC   (MININC),
    .SECCLR   (SECCLR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance n clock edges, sampling outputs 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      edgeNo++;
      if (HOURINC) begin
        hourCnt++;
        hourEdges.push_back(edgeNo);
      end
      if (MININC) begin
        minCnt++;
        minEdges.push_back(edgeNo);
      end
      if (SECCLR) secCnt++;
      if ((int'(HOURINC) + int'(MININC) + int'(SECCLR)) > 1) multiCnt++;
    end
  endtask

  task automatic clearCounts();
    edgeNo   = 0;
    hourCnt  = 0;
    minCnt   = 0;
    secCnt   = 0;
    multiCnt = 0;
    hourEdges.delete();
    minEdges.delete();
  endtask

  task automatic applyReset();
    RST      = 1'b0;
    EN       = 1'b1;
    BTN_MODE = 1'b0;
    BTN_UP   = 1'b0;
    step(3);
    RST = 1'b1;
    step(2);
  endtask

  task automatic pressMode();
    BTN_MODE = 1'b1;
    step(10);
    BTN_MODE = 1'b0;
    step(10);
  endtask

  task automatic applyStimulus(input int modes, input int hold);
    applyReset();
    for (int m = 0; m < modes; m++) pressMode();
    clearCounts();
    BTN_UP = 1'b1;
    step(hold);
    BTN_UP = 1'b0;
    step(20);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int firstEdge;
    int expOff[7];
    int bounce[9];

    // modes, hold, expMode, expHour, expMin, expSec
    vecs[0] = '{0, 20, 0, 0, 0, 0};
    vecs[1] = '{1, 20, 1, 7, 0, 0};
    vecs[2] = '{2, 20, 2, 0, 7, 0};
    vecs[3] = '{3, 20, 3, 0, 0, 1};
    vecs[4] = '{4, 20, 0, 0, 0, 0};
    vecs[5] = '{1,  8, 1, 1, 0, 0};
    vecs[6] = '{2, 10, 2, 0, 2, 0};
    vecs[7] = '{3, 40, 3, 0, 0, 1};

    expOff = '{0, 8, 10, 12, 14, 16, 18};
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

    // Reset state
    RST      = 1'b0;
    EN       = 1'b1;
    BTN_MODE = 1'b0;
    BTN_UP   = 1'b0;
    clearCounts();
    step(3);
    checkOutput("reset SET_MODE", int'(SET_MODE), 0);
    checkOutput("reset HOLD", int'(HOLD), 0);
    checkOutput("reset strobes", int'(HOURINC) + int'(MININC) + int'(SECCLR), 0);

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].modes, vecs[v].hold);
      checkOutput($sformatf("vec%0d SET_MODE", v), int'(SET_MODE), vecs[v].expMode);
      checkOutput($sformatf("vec%0d HOLD", v), int'(HOLD), (vecs[v].expMode != 0) ? 1 : 0);
      checkOutput($sformatf("vec%0d HOURINC count", v), hourCnt, vecs[v].expHour);
      checkOutput($sformatf("vec%0d MININC count", v), minCnt, vecs[v].expMin);
      checkOutput($sformatf("vec%0d SECCLR count", v), secCnt, vecs[v].expSec);
      checkOutput($sformatf("vec%0d multi strobe", v), multiCnt, 0);
    end

    // MODE press latency: 2 sync + 4 samples + 1 register
    applyReset();
    clearCounts();
    BTN_MODE  = 1'b1;
    firstEdge = -1;
    for (int i = 0; i < 20 && firstEdge < 0; i++) begin
      step(1);
      if (SET_MODE != 2'd0) firstEdge = edgeNo;
    end
    checkOutput("mode latency", firstEdge, 7);
    checkOutput("mode latency SET_MODE", int'(SET_MODE), 1);
    checkOutput("mode latency HOLD", int'(HOLD), 1);
    BTN_MODE = 1'b0;
    step(10);

    // Auto-repeat spacing in SET_MIN
    applyReset();
    pressMode();
    pressMode();
    clearCounts();
    BTN_UP = 1'b1;
    step(20);
    BTN_UP = 1'b0;
    step(20);
    checkOutput("repeat MININC count", minCnt, 7);
    checkOutput("repeat HOURINC count", hourCnt, 0);
    checkOutput("repeat SECCLR count", secCnt, 0);
    if (minEdges.size() > 0) checkOutput("repeat first edge", minEdges[0], 7);
    for (int i = 1; i < 7; i++) begin
      if (i < minEdges.size())
        checkOutput($sformatf("repeat offset %0d", i), minEdges[i] - minEdges[0], expOff[i]);
    end

    // Bounce on UP in SET_HOUR
    applyReset();
    pressMode();
    clearCounts();
    for (int i = 0; i < 9; i++) begin
      step(1);
      BTN_UP = bounce[i][0];
    end
    step(4);
    BTN_UP = 1'b0;
    step(20);
    checkOutput("bounce HOURINC count", hourCnt, 1);
    if (hourEdges.size() > 0) checkOutput("bounce HOURINC edge", hourEdges[0], 13);
    checkOutput("bounce MININC count", minCnt, 0);

    // MODE and UP together in SET_HOUR
    applyReset();
    pressMode();
    clearCounts();
    BTN_MODE = 1'b1;
    BTN_UP   = 1'b1;
    step(30);
    checkOutput("simul SET_MODE", int'(SET_MODE), 2);
    checkOutput("simul HOURINC count", hourCnt, 0);
    checkOutput("simul MININC count", minCnt, 0);
    BTN_MODE = 1'b0;
    step(30);
    checkOutput("simul held no repeat", minCnt, 0);
    BTN_UP = 1'b0;
    step(15);
    BTN_UP = 1'b1;
    step(8);
    BTN_UP = 1'b0;
    step(15);
    checkOutput("simul re-press MININC", minCnt, 1);
    checkOutput("simul SET_MODE after", int'(SET_MODE), 2);

    // Asynchronous reset while a repeat strobe is high
    applyReset();
    pressMode();
    clearCounts();
    BTN_UP = 1'b1;
    for (int i = 0; i < 40 && hourCnt < 2; i++) step(1);
    checkOutput("pre-reset HOURINC", int'(HOURINC), 1);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("async reset SET_MODE", int'(SET_MODE), 0);
    checkOutput("async reset HOLD", int'(HOLD), 0);
    checkOutput("async reset HOURINC", int'(HOURINC), 0);
    step(2);
    RST = 1'b1;
    clearCounts();
    step(30);
    checkOutput("post-reset strobes", hourCnt + minCnt + secCnt, 0);
    checkOutput("post-reset SET_MODE", int'(SET_MODE), 0);
    BTN_UP = 1'b0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
